// File: rtl/tinyml_mem_pkg.sv
// Shared definitions for the tinyml DRAM movers: address/length widths,
// the store FSM state type and the byte range test used by store_m.
package tinyml_mem_pkg;

  localparam int DRAM_ADDR_W = 24;
  localparam int LEN_W       = 20;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TILE = 2'd1,
    ST_WRITING   = 2'd2,
    ST_DONE      = 2'd3
  } store_state_t;

  // A byte starting at bit (cnt + off) holds at least one payload bit when
  // that start lies below len; the extra bit keeps the sum from wrapping.
  function automatic logic bit_in_range(input logic [LEN_W-1:0] cnt,
                                        input logic [LEN_W-1:0] off,
                                        input logic [LEN_W-1:0] len);
    return ({1'b0, cnt} + {1'b0, off}) < {1'b0, len};
  endfunction

endpackage

// File: rtl/store_m_tile_serializer.sv
// Tile shift register for store_m: loads a tile in parallel and presents the
// next MSB-first byte, with the index of the byte currently on the write port.
module tile_serializer #(
  parameter  int TILE_WIDTH = 256,
  localparam int NUM_BYTES  = TILE_WIDTH / 8,
  localparam int IDX_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [TILE_WIDTH-1:0] tile,
  output logic [7:0]            next_byte,
  output logic [IDX_W-1:0]      idx,
  output logic                  last
);

  logic [TILE_WIDTH-1:0] sreg;

  // Byte 0 leaves straight from the tile input on the load cycle, so the
  // register only keeps the bytes still to be sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load) begin
      sreg <= tile << 8;
      idx  <= '0;
    end else if (shift) begin
      sreg <= sreg << 8;
      idx  <= idx + 1'b1;
    end
  end

  assign next_byte = sreg[TILE_WIDTH-1 -: 8];
  assign last      = (idx == IDX_W'(NUM_BYTES - 1));

endmodule

// File: rtl/store_m.sv
// Tile-to-DRAM byte writer: takes tiles, writes them MSB byte first to
// consecutive byte addresses. STORE_M_ZERO_PAD_EN pads the final tile with 8'h00.
//
// state        | meaning
// ST_IDLE      | waiting for valid_in; latches address and length
// ST_WAIT_TILE | tile_ready high, waiting for tile_valid
// ST_WRITING   | one byte per cycle for NUM_BYTES cycles
// ST_DONE      | raises valid_out next cycle, returns to idle
module store_m
  import tinyml_mem_pkg::*;
#(
  parameter int TILE_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [DRAM_ADDR_W-1:0] dram_addr,
  input  logic [LEN_W-1:0]       length,
  input  logic [TILE_WIDTH-1:0]  tile_in,
  input  logic                   tile_valid,
  output logic                   tile_ready,
  output logic                   mem_we,
  output logic [DRAM_ADDR_W-1:0] mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   busy,
  output logic                   valid_out
);

  localparam int NUM_BYTES = TILE_WIDTH / 8;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  store_state_t           state;
  logic [DRAM_ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       bit_cnt;

  logic [7:0]       ser_byte;
  logic [IDX_W-1:0] ser_idx;
  logic             ser_last;

  logic             hs;
  logic             emit;
  logic [7:0]       em_byte;
  logic [LEN_W-1:0] em_off;
  logic             in_rng;
  logic [LEN_W-1:0] new_cnt;

  assign tile_ready = (state == ST_WAIT_TILE);
  assign busy       = (state != ST_IDLE);
  assign hs         = tile_ready && tile_valid;

  tile_serializer #(.TILE_WIDTH(TILE_WIDTH)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (hs),
    .shift     (state == ST_WRITING),
    .tile      (tile_in),
    .next_byte (ser_byte),
    .idx       (ser_idx),
    .last      (ser_last)
  );

  // The write port is registered one byte ahead: byte 0 is launched on the
  // handshake edge and byte idx+1 while byte idx is on the bus.
  always_comb begin
    emit    = hs || ((state == ST_WRITING) && !ser_last);
    em_byte = hs ? tile_in[TILE_WIDTH-1 -: 8] : ser_byte;
    em_off  = hs ? '0 : ((LEN_W'(ser_idx) + LEN_W'(1)) << 3);
    in_rng  = bit_in_range(bit_cnt, em_off, len_q);
    new_cnt = bit_cnt + LEN_W'(TILE_WIDTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      bit_cnt   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valid_out <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      valid_out <= 1'b0;

      if (emit) begin
`ifdef STORE_M_ZERO_PAD_EN
        mem_we    <= 1'b1;
        mem_addr  <= addr_q;
        mem_wdata <= in_rng ? em_byte : 8'h00;
        addr_q    <= addr_q + DRAM_ADDR_W'(1);
`else
        if (in_rng) begin
          mem_we    <= 1'b1;
          mem_addr  <= addr_q;
          mem_wdata <= em_byte;
          addr_q    <= addr_q + DRAM_ADDR_W'(1);
        end
`endif
      end

      case (state)
        ST_IDLE: begin
          if (valid_in) begin
            addr_q  <= dram_addr;
            len_q   <= length;
            bit_cnt <= '0;
            state   <= (length == '0) ? ST_DONE : ST_WAIT_TILE;
          end
        end
        ST_WAIT_TILE: begin
          if (tile_valid) state <= ST_WRITING;
        end
        ST_WRITING: begin
          if (ser_last) begin
            bit_cnt <= new_cnt;
            state   <= (new_cnt < len_q) ? ST_WAIT_TILE : ST_DONE;
          end
        end
        ST_DONE: begin
          valid_out <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
